song_sequencer: RTL and testbench

- Plays a stored song by sequencing the sound datapath.
- Fetches 16-bit song entries from a synchronous song ROM. Each entry drives the 8-bit note mask and 2-bit octave shift for a programmed duration, followed by a short articulation gap.
- Sits between the song ROM and the sound output path and produces the same {notes, shift} word consumed by the tone/PWM stage.
- Provides start/pause/stop control for the auto-play and game modes.

---
 rtl/song_pkg.sv | 21 ++
 rtl/song_sequencer_unit_ticker.sv | 27 ++
 rtl/song_sequencer.sv | 131 +++++++++++++
 tb/tb_song_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared types and song-entry field layout for the song sequencer.
package song_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_PLAY,
      S_GAP
   } state_t;

   localparam int DUR_MSB   = 15;
   localparam int DUR_LSB   = 10;
   localparam int NOTES_MSB = 9;
   localparam int NOTES_LSB = 2;
   localparam int SHIFT_MSB = 1;
   localparam int SHIFT_LSB = 0;

   localparam logic [DUR_MSB-DUR_LSB:0] END_DURATION = '0;

endpackage

// File: rtl/song_sequencer_unit_ticker.sv
// unit_ticker: divides the clock by TICKS_PER_UNIT while enabled, emitting a
// one-cycle unit_tick on the last tick of each unit; clr restarts the count.
module unit_ticker #(
   parameter int TICKS_PER_UNIT = 6_250_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic unit_tick
);
   localparam int TW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
   localparam logic [TW-1:0] LAST = TW'(TICKS_PER_UNIT - 1);

   logic [TW-1:0] cnt;

   assign unit_tick = en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= unit_tick ? '0 : cnt + TW'(1);
      end
   end

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: fetches song entries and plays each note for its duration plus
// a silent gap. Define SONG_LOOP_EN to restart from song_base at the end marker.
module song_sequencer #(
   parameter int TICKS_PER_UNIT = 6_250_000,
   parameter int GAP_CYCLES     = 1_000_000,
   parameter int ADDR_W         = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic [ADDR_W-1:0] song_base,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic [7:0]        notes,
   output logic [1:0]        shift,
   output logic              playing,
   output logic              paused,
   output logic              done
);
   import song_pkg::*;

   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        note_r;
   logic [1:0]        shift_r;
   logic [5:0]        unit_cnt;
   logic [GW-1:0]     gap_cnt;
   logic              unit_tick;
   logic              end_marker;
`ifdef SONG_LOOP_EN
   logic [ADDR_W-1:0] base_r;
`endif

   unit_ticker #(.TICKS_PER_UNIT(TICKS_PER_UNIT)) u_ticker (
      .clk       (clk),
      .rst       (rst),
      .en        (state == S_PLAY && !pause),
      .clr       (state != S_PLAY),
      .unit_tick (unit_tick)
   );

   assign end_marker = (rom_data[DUR_MSB:DUR_LSB] == END_DURATION);

   // Pause silences the sound path immediately, without waiting for an edge.
   assign notes    = (state == S_PLAY && !pause) ? note_r  : '0;
   assign shift    = (state == S_PLAY && !pause) ? shift_r : '0;
   assign paused   = pause && (state == S_PLAY || state == S_GAP);
   assign done     = (state == S_LOAD) && end_marker && !stop;
   assign rom_addr = addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         addr     <= '0;
         note_r   <= '0;
         shift_r  <= '0;
         unit_cnt <= '0;
         gap_cnt  <= '0;
         rom_en   <= 1'b0;
         playing  <= 1'b0;
`ifdef SONG_LOOP_EN
         base_r   <= '0;
`endif
      end else begin
         rom_en <= 1'b0;
         if (stop) begin
            state   <= S_IDLE;
            playing <= 1'b0;
         end else begin
            case (state)
               S_IDLE: if (start) begin
                  addr    <= song_base;
`ifdef SONG_LOOP_EN
                  base_r  <= song_base;
`endif
                  playing <= 1'b1;
                  rom_en  <= 1'b1;
                  state   <= S_FETCH;
               end
               S_FETCH: state <= S_LOAD;
               S_LOAD: if (end_marker) begin
`ifdef SONG_LOOP_EN
                  addr    <= base_r;
                  rom_en  <= 1'b1;
                  state   <= S_FETCH;
`else
                  playing <= 1'b0;
                  state   <= S_IDLE;
`endif
               end else begin
                  note_r   <= rom_data[NOTES_MSB:NOTES_LSB];
                  shift_r  <= rom_data[SHIFT_MSB:SHIFT_LSB];
                  unit_cnt <= rom_data[DUR_MSB:DUR_LSB];
                  state    <= S_PLAY;
               end
               S_PLAY: if (unit_tick) begin
                  if (unit_cnt == 6'd1) begin
                     if (GAP_CYCLES == 0) begin
                        addr   <= addr + ADDR_W'(1);
                        rom_en <= 1'b1;
                        state  <= S_FETCH;
                     end else begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                     end
                  end else begin
                     unit_cnt <= unit_cnt - 6'd1;
                  end
               end
               S_GAP: if (!pause) begin
                  if (gap_cnt == GAP_LAST) begin
                     addr   <= addr + ADDR_W'(1);
                     rom_en <= 1'b1;
                     state  <= S_FETCH;
                  end else begin
                     gap_cnt <= gap_cnt + GW'(1);
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: remaining-cycle reference model checked every cycle,
// directed scenarios with literal expectations, then randomized control traffic.
module tb_song_sequencer;
   localparam int TPU = 4;
   localparam int GAP = 2;

   localparam int M_IDLE  = 0;
   localparam int M_FETCH = 1;
   localparam int M_LOAD  = 2;
   localparam int M_PLAY  = 3;
   localparam int M_GAP   = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        pause = 1'b0;
   logic [3:0]  song_base = '0;
   logic        rom_en;
   logic [3:0]  rom_addr;
   logic [15:0] rom_data = '0;
   logic [7:0]  notes;
   logic [1:0]  shift;
   logic        playing;
   logic        paused;
   logic        done;

   logic [15:0] rom [16];

   int checks = 0;
   int failures = 0;
   logic cmp_on = 1'b0;

   int         m_mode = M_IDLE;
   logic [3:0] m_addr = '0;
   logic [3:0] m_base = '0;
   logic [7:0] m_notes = '0;
   logic [1:0] m_shift = '0;
   int         m_rem = 0;
   logic       m_playing = 1'b0;

   song_sequencer #(.TICKS_PER_UNIT(TPU), .GAP_CYCLES(GAP), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .pause     (pause),
      .song_base (song_base),
      .rom_en    (rom_en),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .notes     (notes),
      .shift     (shift),
      .playing   (playing),
      .paused    (paused),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: check outputs mid-cycle, then apply the coming edge.
   always @(negedge clk) begin
      logic [15:0] e;
      logic        on;
      if (cmp_on) begin
         on = (m_mode == M_PLAY) && !pause;
         chk("rom_en", rom_en, m_mode == M_FETCH);
         if (m_mode == M_FETCH) chk("rom_addr", rom_addr, m_addr);
         chk("notes", notes, on ? m_notes : 8'h00);
         chk("shift", shift, on ? m_shift : 2'd0);
         chk("playing", playing, m_playing);
         chk("paused", paused, pause && (m_mode == M_PLAY || m_mode == M_GAP));
         chk("done", done, (m_mode == M_LOAD) && !stop && (rom[m_addr][15:10] == 6'd0));

         if (rst) begin
            m_mode = M_IDLE; m_playing = 1'b0; m_addr = '0;
         end else if (stop) begin
            m_mode = M_IDLE; m_playing = 1'b0;
         end else begin
            case (m_mode)
               M_IDLE: if (start) begin
                  m_addr = song_base; m_base = song_base; m_playing = 1'b1; m_mode = M_FETCH;
               end
               M_FETCH: m_mode = M_LOAD;
               M_LOAD: begin
                  e = rom[m_addr];
                  if (e[15:10] == 6'd0) begin
`ifdef SONG_LOOP_EN
                     m_addr = m_base; m_mode = M_FETCH;
`else
                     m_playing = 1'b0; m_mode = M_IDLE;
`endif
                  end else begin
                     m_notes = e[9:2]; m_shift = e[1:0];
                     m_rem = int'(e[15:10]) * TPU; m_mode = M_PLAY;
                  end
               end
               M_PLAY: if (!pause) begin
                  m_rem--;
                  if (m_rem == 0) begin
                     if (GAP == 0) begin m_addr++; m_mode = M_FETCH; end
                     else begin m_rem = GAP; m_mode = M_GAP; end
                  end
               end
               M_GAP: if (!pause) begin
                  m_rem--;
                  if (m_rem == 0) begin m_addr++; m_mode = M_FETCH; end
               end
               default: m_mode = M_IDLE;
            endcase
         end
      end
   end

   task automatic do_stop();
      @(posedge clk); #1 stop = 1'b1; start = 1'b0; pause = 1'b0;
      @(posedge clk); #1 stop = 1'b0;
   endtask

   initial begin
      int note_cnt, p_cnt, d_cnt, en_cnt, pl_cnt;
      for (int i = 0; i < 16; i++) rom[i] = 16'h0000;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_notes", notes, 8'h00);
      chk("reset_playing", playing, 1'b0);
      chk("reset_rom_en", rom_en, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_rom_addr", rom_addr, 4'h0);
      @(posedge clk); #1 rst = 1'b0; cmp_on = 1'b1;

      // Basic note, gap, end marker.
      rom[0] = 16'h0805; rom[1] = 16'h0000; song_base = 4'd0;
      @(posedge clk); #1 start = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1 start = 1'b0;
         @(negedge clk);
         case (k + 1)
            1:  begin chk("s1_rom_en", rom_en, 1'b1); chk("s1_addr0", rom_addr, 4'd0); end
            3:  begin chk("s1_notes_first", notes, 8'h01); chk("s1_shift", shift, 2'd1); end
            10: chk("s1_notes_last", notes, 8'h01);
            11: chk("s1_gap", notes, 8'h00);
            13: begin chk("s1_fetch1", rom_en, 1'b1); chk("s1_addr1", rom_addr, 4'd1); end
            14: chk("s1_done", done, 1'b1);
`ifdef SONG_LOOP_EN
            15: begin chk("s1_loop_playing", playing, 1'b1); chk("s1_loop_addr", rom_addr, 4'd0); end
`else
            15: chk("s1_playing_off", playing, 1'b0);
`endif
            default: ;
         endcase
      end
      do_stop();

      // Pause for 5 cycles starting 3 cycles into the note.
      note_cnt = 0; p_cnt = 0; d_cnt = 0;
      @(posedge clk); #1 start = 1'b1;
      for (int k = 0; k < 21; k++) begin
         @(posedge clk); #1 start = 1'b0; pause = (k >= 5 && k <= 9);
         @(negedge clk);
         if (notes != 8'h00) note_cnt++;
         if (paused) p_cnt++;
         if (done) d_cnt++;
         if (k + 1 == 6)  begin chk("s2_paused", paused, 1'b1); chk("s2_silent", notes, 8'h00); end
         if (k + 1 == 11) chk("s2_resumed", notes, 8'h01);
         if (k + 1 == 15) chk("s2_note_tail", notes, 8'h01);
         if (k + 1 == 16) chk("s2_gap", notes, 8'h00);
      end
      chk("s2_note_cycles", note_cnt, 8);
      chk("s2_pause_cycles", p_cnt, 5);
      chk("s2_done_count", d_cnt, 1);
      do_stop();

      // Stop during PLAY, then replay from base.
      d_cnt = 0;
      @(posedge clk); #1 start = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1 start = 1'b0; stop = (k == 4);
         @(negedge clk);
         if (done) d_cnt++;
         if (k + 1 == 6) begin chk("s3_stop_notes", notes, 8'h00); chk("s3_stop_playing", playing, 1'b0); end
      end
      chk("s3_no_done", d_cnt, 0);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk); chk("s3_replay_addr", rom_addr, 4'd0); chk("s3_replay_en", rom_en, 1'b1);
      do_stop();

      // start and stop together in IDLE.
      en_cnt = 0; pl_cnt = 0;
      @(posedge clk); #1 start = 1'b1; stop = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1 start = 1'b0; stop = 1'b0;
         @(negedge clk);
         if (rom_en) en_cnt++;
         if (playing) pl_cnt++;
      end
      chk("s4_rom_en_never", en_cnt, 0);
      chk("s4_playing_never", pl_cnt, 0);

      // Address wrap from 15 to 0.
      rom[15] = 16'h0404; rom[0] = 16'h0000; song_base = 4'd15;
      @(posedge clk); #1 start = 1'b1;
      for (int k = 0; k < 11; k++) begin
         @(posedge clk); #1 start = 1'b0;
         @(negedge clk);
         case (k + 1)
            1:  chk("s5_addr15", rom_addr, 4'd15);
            3:  begin chk("s5_notes", notes, 8'h01); chk("s5_shift", shift, 2'd0); end
            9:  begin chk("s5_wrap_en", rom_en, 1'b1); chk("s5_wrap_addr", rom_addr, 4'd0); end
            10: chk("s5_done", done, 1'b1);
            default: ;
         endcase
      end
      do_stop();

      // Randomized control traffic over a random song.
      for (int i = 0; i < 16; i++) begin
         rom[i][15:10] = 6'($urandom_range(0, 3));
         rom[i][9:0]   = 10'($urandom);
      end
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         start     = ($urandom_range(0, 9) == 0);
         stop      = ($urandom_range(0, 59) == 0);
         pause     = ($urandom_range(0, 4) == 0);
         rst       = ($urandom_range(0, 499) == 0);
         song_base = 4'($urandom);
      end
      @(posedge clk); #1 rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      @(negedge clk);
      @(posedge clk); #1 cmp_on = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
